// File: rtl/cpu_mc_ctrl.sv
// rtl/cpu_mc_ctrl.sv - multi-cycle fetch/exec/mem/wb sequencer with bus timeout trap
module cpu_mc_ctrl #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000),
   parameter int                    TIMEOUT    = 16,
   parameter int                    CNT_WIDTH  = 32
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst_n,
   input  logic                  i_sys_halt,
   output logic                  o_rom_rd_en,
   output logic [ADDR_WIDTH-1:0] o_rom_rd_addr,
   input  logic                  i_rom_rd_valid,
   input  logic [INST_WIDTH-1:0] i_rom_rd_data,
   output logic [INST_WIDTH-1:0] o_ctl_inst,
   input  logic                  i_idu_ctr_ram_rd_en,
   input  logic                  i_idu_ctr_ram_wr_en,
   input  logic                  i_idu_ctr_reg_wr_en,
   input  logic                  i_exu_jmp_en,
   input  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc,
   output logic                  o_ctl_ram_rd_en,
   output logic                  o_ctl_ram_wr_en,
   input  logic                  i_ram_ack,
   output logic                  o_ctl_gpr_wr_en,
   output logic [ADDR_WIDTH-1:0] o_ctl_pc,
   output logic                  o_ctl_retire,
   output logic [CNT_WIDTH-1:0]  o_ctl_retire_cnt,
   output logic [2:0]            o_ctl_state,
   output logic                  o_ctl_err
);

   localparam int WAIT_W = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_WB    = 3'd4,
      S_HALT  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                wait_expired;
   logic                mem_is_wr;
   logic                jmp_misaligned;
   logic                wb_fire;
   logic [ADDR_WIDTH-1:0] pc;
   logic [INST_WIDTH-1:0] inst;
   logic [CNT_WIDTH-1:0]  retire_cnt;
   logic                err;

   assign wait_expired   = (wait_cnt == WAIT_W'(TIMEOUT - 1));
   assign jmp_misaligned = i_exu_jmp_en && (i_exu_jmp_pc[1:0] != 2'b00);
   assign wb_fire        = (state == S_WB) && !jmp_misaligned;

   // Next-state selection and state-decoded request/strobe outputs
   always_comb begin
      state_nxt       = state;
      o_rom_rd_en     = 1'b0;
      o_ctl_ram_rd_en = 1'b0;
      o_ctl_ram_wr_en = 1'b0;
      o_ctl_gpr_wr_en = 1'b0;
      o_ctl_retire    = 1'b0;
      case (state)
         S_IDLE: state_nxt = S_FETCH;
         S_FETCH: begin
            o_rom_rd_en = 1'b1;
            if (i_rom_rd_valid)
               state_nxt = S_EXEC;
            else if (wait_expired)
               state_nxt = S_ERR;
         end
         S_EXEC: begin
            if (i_idu_ctr_ram_rd_en && i_idu_ctr_ram_wr_en)
               state_nxt = S_ERR;
            else if (i_idu_ctr_ram_rd_en || i_idu_ctr_ram_wr_en)
               state_nxt = S_MEM;
            else
               state_nxt = S_WB;
         end
         S_MEM: begin
            o_ctl_ram_rd_en = !mem_is_wr;
            o_ctl_ram_wr_en = mem_is_wr;
            if (i_ram_ack)
               state_nxt = S_WB;
            else if (wait_expired)
               state_nxt = S_ERR;
         end
         S_WB: begin
            // A misaligned jump target kills the instruction before it commits
            o_ctl_gpr_wr_en = i_idu_ctr_reg_wr_en && !jmp_misaligned;
            o_ctl_retire    = !jmp_misaligned;
            if (jmp_misaligned)
               state_nxt = S_ERR;
            else if (i_sys_halt)
               state_nxt = S_HALT;
            else
               state_nxt = S_FETCH;
         end
         S_HALT:  state_nxt = S_HALT;
         S_ERR:   state_nxt = S_ERR;
         default: state_nxt = S_ERR;
      endcase
   end

   // State register
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Bus wait counter: restarts on every state change, counts stalled FETCH/MEM cycles
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n)
         wait_cnt <= '0;
      else if (state_nxt != state)
         wait_cnt <= '0;
      else if (state == S_FETCH || state == S_MEM)
         wait_cnt <= wait_cnt + WAIT_W'(1);
   end

   // Instruction latch and memory access class captured in EXEC
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         inst      <= '0;
         mem_is_wr <= 1'b0;
      end else begin
         if (state == S_FETCH && i_rom_rd_valid)
            inst <= i_rom_rd_data;
         if (state == S_EXEC)
            mem_is_wr <= i_idu_ctr_ram_wr_en;
      end
   end

   // PC update and retire counting on the edge leaving a committing WB
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         pc         <= RESET_PC;
         retire_cnt <= '0;
      end else if (wb_fire) begin
         pc         <= i_exu_jmp_en ? i_exu_jmp_pc : pc + ADDR_WIDTH'(4);
         retire_cnt <= retire_cnt + CNT_WIDTH'(1);
      end
   end

   // Sticky error flag
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n)
         err <= 1'b0;
      else if (state_nxt == S_ERR)
         err <= 1'b1;
   end

   assign o_rom_rd_addr    = pc;
   assign o_ctl_pc         = pc;
   assign o_ctl_inst       = inst;
   assign o_ctl_retire_cnt = retire_cnt;
   assign o_ctl_state      = state;
   assign o_ctl_err        = err;

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// tb/tb_cpu_mc_ctrl.sv - scoreboard bench for cpu_mc_ctrl
module tb_cpu_mc_ctrl;
   localparam int          AW     = 32;
   localparam int          IW     = 32;
   localparam int          CW     = 4;
   localparam int          TO     = 4;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          sys_halt = 1'b0;
   logic          rom_rd_en;
   logic [AW-1:0] rom_rd_addr;
   logic          rom_valid = 1'b0;
   logic [IW-1:0] rom_data = '0;
   logic [IW-1:0] ctl_inst;
   logic          ld_en = 1'b0;
   logic          st_en = 1'b0;
   logic          rw_en = 1'b0;
   logic          jmp_en = 1'b0;
   logic [AW-1:0] jmp_pc = '0;
   logic          ram_rd_en;
   logic          ram_wr_en;
   logic          ram_ack = 1'b0;
   logic          gpr_wr_en;
   logic [AW-1:0] ctl_pc;
   logic          retire;
   logic [CW-1:0] retire_cnt;
   logic [2:0]    ctl_state;
   logic          ctl_err;

   always #5 clk = ~clk;

   cpu_mc_ctrl #(
      .ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC(RST_PC), .TIMEOUT(TO), .CNT_WIDTH(CW)
   ) dut (
      .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_sys_halt(sys_halt),
      .o_rom_rd_en(rom_rd_en), .o_rom_rd_addr(rom_rd_addr),
      .i_rom_rd_valid(rom_valid), .i_rom_rd_data(rom_data),
      .o_ctl_inst(ctl_inst),
      .i_idu_ctr_ram_rd_en(ld_en), .i_idu_ctr_ram_wr_en(st_en), .i_idu_ctr_reg_wr_en(rw_en),
      .i_exu_jmp_en(jmp_en), .i_exu_jmp_pc(jmp_pc),
      .o_ctl_ram_rd_en(ram_rd_en), .o_ctl_ram_wr_en(ram_wr_en), .i_ram_ack(ram_ack),
      .o_ctl_gpr_wr_en(gpr_wr_en), .o_ctl_pc(ctl_pc), .o_ctl_retire(retire),
      .o_ctl_retire_cnt(retire_cnt), .o_ctl_state(ctl_state), .o_ctl_err(ctl_err)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        gpr;
      logic [3:0]  cnt;
   } rec_t;

   rec_t        sb_q[$];
   rec_t        mon_r;
   int          checks = 0;
   int          errors = 0;
   int          gpr_exp = 0;
   int          gpr_seen = 0;
   int          n_ret = 0;
   logic [31:0] pc_m;
   logic [3:0]  cnt_m;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Retire monitor: every retire pulse must match the oldest pending instruction
   always @(negedge clk) begin
      if (rst_n) begin
         if (gpr_wr_en) gpr_seen++;
         if (retire) begin
            if (sb_q.size() == 0) begin
               check("retire_unexpected", 64'(retire), 64'd0);
            end else begin
               mon_r = sb_q.pop_front();
               check("ret_pc", 64'(ctl_pc), 64'(mon_r.pc));
               check("ret_inst", 64'(ctl_inst), 64'(mon_r.inst));
               check("ret_gpr", 64'(gpr_wr_en), 64'(mon_r.gpr));
               check("ret_cnt", 64'(retire_cnt), 64'(mon_r.cnt));
            end
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      rom_valid = 1'b0; ram_ack = 1'b0; ld_en = 1'b0; st_en = 1'b0;
      rw_en = 1'b0; jmp_en = 1'b0; sys_halt = 1'b0;
      #1;
      check("rst_state", 64'(ctl_state), 64'd0);
      check("rst_pc", 64'(ctl_pc), 64'(RST_PC));
      check("rst_inst", 64'(ctl_inst), 64'd0);
      check("rst_cnt", 64'(retire_cnt), 64'd0);
      check("rst_err", 64'(ctl_err), 64'd0);
      check("rst_reqs", 64'({rom_rd_en, ram_rd_en, ram_wr_en, gpr_wr_en, retire}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("idle_state", 64'(ctl_state), 64'd0);
      @(negedge clk);
      pc_m = RST_PC;
      cnt_m = '0;
   endtask

   // Drive one instruction through the pipeline from a FETCH negedge
   task automatic run_inst(input logic [31:0] inst, input bit ld, input bit st, input bit rw,
                           input bit je, input logic [31:0] jpc, input int rom_dly,
                           input int ram_dly, input bit hlt);
      bit   mis;
      rec_t r;
      mis = je && (jpc[1:0] != 2'b00);
      if (!mis && !(ld && st)) begin
         r.pc = pc_m; r.inst = inst; r.gpr = rw; r.cnt = cnt_m;
         sb_q.push_back(r);
         gpr_exp += int'(rw);
      end
      for (int i = 0; i <= rom_dly; i++) begin
         check("fetch_state", 64'(ctl_state), 64'd1);
         check("fetch_rd_en", 64'(rom_rd_en), 64'd1);
         check("fetch_addr", 64'(rom_rd_addr), 64'(pc_m));
         rom_valid = (i == rom_dly);
         rom_data = inst;
         @(negedge clk);
      end
      rom_valid = 1'b0;
      check("exec_state", 64'(ctl_state), 64'd2);
      check("exec_inst", 64'(ctl_inst), 64'(inst));
      ld_en = ld; st_en = st; rw_en = rw; jmp_en = je; jmp_pc = jpc; sys_halt = hlt;
      @(negedge clk);
      ld_en = 1'b0; st_en = 1'b0;
      if (ld && st) begin
         check("ldst_err_state", 64'(ctl_state), 64'd6);
         check("ldst_err_flag", 64'(ctl_err), 64'd1);
         rw_en = 1'b0; jmp_en = 1'b0; sys_halt = 1'b0;
         return;
      end
      if (ld || st) begin
         for (int i = 0; i <= ram_dly; i++) begin
            check("mem_state", 64'(ctl_state), 64'd3);
            check("mem_rd_en", 64'(ram_rd_en), 64'(ld));
            check("mem_wr_en", 64'(ram_wr_en), 64'(st));
            ram_ack = (i == ram_dly);
            @(negedge clk);
         end
         ram_ack = 1'b0;
      end
      check("wb_state", 64'(ctl_state), 64'd4);
      @(negedge clk);
      rw_en = 1'b0; jmp_en = 1'b0; sys_halt = 1'b0;
      if (mis) begin
         check("mis_state", 64'(ctl_state), 64'd6);
         check("mis_err", 64'(ctl_err), 64'd1);
         check("mis_pc", 64'(ctl_pc), 64'(pc_m));
         check("mis_cnt", 64'(retire_cnt), 64'(cnt_m));
      end else begin
         pc_m = je ? jpc : pc_m + 32'd4;
         cnt_m = cnt_m + 4'd1;
         n_ret++;
         check("post_state", 64'(ctl_state), hlt ? 64'd5 : 64'd1);
         check("post_pc", 64'(ctl_pc), 64'(pc_m));
         check("post_cnt", 64'(retire_cnt), 64'(cnt_m));
         check("post_err", 64'(ctl_err), 64'd0);
      end
   endtask

   initial begin
      int cls;
      logic [31:0] tgt;
      #2;
      do_reset();

      // ALU, load with 3-cycle ack delay, store without GPR write
      run_inst(32'h0000_0013, 0, 0, 1, 0, 32'h0, 0, 0, 0);
      check("alu_pc", 64'(ctl_pc), 64'h8000_0004);
      check("alu_cnt", 64'(retire_cnt), 64'd1);
      run_inst(32'h0000_2003, 1, 0, 1, 0, 32'h0, 0, 3, 0);
      run_inst(32'h0000_2023, 0, 1, 0, 0, 32'h0, 1, 0, 0);

      // Taken jump, then the fetch address must follow it
      run_inst(32'h0000_006f, 0, 0, 1, 1, 32'h8000_0100, 0, 0, 0);
      check("jmp_addr", 64'(rom_rd_addr), 64'h8000_0100);
      run_inst(32'h0000_0093, 0, 0, 1, 0, 32'h0, 2, 0, 0);

      // Random mix until 17 retires so the 4-bit counter wraps
      while (n_ret < 17) begin
         cls = int'($urandom_range(0, 3));
         tgt = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
         run_inst($urandom, cls == 1, cls == 2, $urandom_range(0, 1) == 1, cls == 3, tgt,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
      end
      check("cnt_wrap", 64'(retire_cnt), 64'd1);

      // Misaligned jump target traps without committing
      run_inst(32'h0000_006f, 0, 0, 1, 1, 32'h8000_0102, 0, 0, 0);

      // Fetch timeout
      do_reset();
      for (int i = 0; i < TO; i++) begin
         check("to_fetch_state", 64'(ctl_state), 64'd1);
         @(negedge clk);
      end
      check("to_err_state", 64'(ctl_state), 64'd6);
      check("to_err_flag", 64'(ctl_err), 64'd1);
      check("to_rom_rd_en", 64'(rom_rd_en), 64'd0);

      // Valid on the last allowed cycle wins, then halt
      do_reset();
      run_inst(32'h0000_0013, 0, 0, 0, 0, 32'h0, TO - 1, 0, 0);
      run_inst(32'h0000_0113, 0, 0, 1, 0, 32'h0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         rom_valid = 1'b1;
         @(negedge clk);
         check("halt_state", 64'(ctl_state), 64'd5);
         check("halt_rom_rd_en", 64'(rom_rd_en), 64'd0);
      end
      rom_valid = 1'b0;

      // Reset in the middle of a load
      do_reset();
      rom_valid = 1'b1; rom_data = 32'h0000_2083;
      @(negedge clk);
      rom_valid = 1'b0; ld_en = 1'b1;
      @(negedge clk);
      ld_en = 1'b0;
      check("mm_state", 64'(ctl_state), 64'd3);
      check("mm_rd_en", 64'(ram_rd_en), 64'd1);
      #2;
      do_reset();

      // Load and store decoded together
      run_inst(32'h0000_0003, 1, 1, 0, 0, 32'h0, 0, 0, 0);

      @(negedge clk);
      check("sb_empty", 64'(sb_q.size()), 64'd0);
      check("gpr_pulses", 64'(gpr_seen), 64'(gpr_exp));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
